// File: rtl/frame_pattern_gen.sv
// Test-frame source: counter / PRBS-9 / fixed / walking-ones words on a valid/ready stream.
// Define FRAME_PATTERN_GEN_PRBS_EN to build the PRBS-9 LFSR; otherwise mode 1 acts as the counter.
module frame_pattern_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [LEN_W-1:0]  gap_len,
    input  logic              cont,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              sof,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  gap_q, gap_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_seed;
    logic [LEN_W-1:0]  cfg_len;
    logic [DATA_W-1:0] word_first;
    logic [DATA_W-1:0] word_next;
    logic              transfer;
    logic              load_first;
    logic              advance;

`ifdef FRAME_PATTERN_GEN_PRBS_EN
    logic [8:0]        lfsr_q, lfsr_d;
    logic [DATA_W+8:0] prbs_first;
    logic [DATA_W+8:0] prbs_next;

    // Steps x^9+x^5+1 DATA_W times; returns {new_state, word} with the first bit in the MSB.
    function automatic logic [DATA_W+8:0] prbs_adv(input logic [8:0] s_in);
        logic [8:0]        s;
        logic [DATA_W-1:0] w;
        s = s_in;
        w = '0;
        for (int k = 0; k < DATA_W; k++) begin
            w = {w[DATA_W-2:0], s[8]};
            s = {s[7:0], s[8] ^ s[4]};
        end
        return {s, w};
    endfunction

    assign prbs_first = prbs_adv(9'h1FF);
    assign prbs_next  = prbs_adv(lfsr_q);
`endif

    assign transfer = valid_q && ready;

    // In IDLE the first word is built from the live inputs, since config latches on the same edge.
    assign cfg_mode = (state_q == IDLE) ? mode      : mode_q;
    assign cfg_seed = (state_q == IDLE) ? seed      : seed_q;
    assign cfg_len  = (state_q == IDLE) ? frame_len : len_q;

    always_comb begin
        word_first = cfg_seed;
        word_next  = data_q + DATA_W'(1);
        case (cfg_mode)
            2'd2: word_first = cfg_seed;
            2'd3: word_first = DATA_W'(1);
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            2'd1: word_first = prbs_first[DATA_W-1:0];
`endif
            default: word_first = cfg_seed;
        endcase
        case (mode_q)
            2'd2: word_next = seed_q;
            2'd3: word_next = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            2'd1: word_next = prbs_next[DATA_W-1:0];
`endif
            default: word_next = data_q + DATA_W'(1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        len_d      = len_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        done_d     = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
        lfsr_d     = lfsr_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && frame_len != '0) begin
                    mode_d     = mode;
                    seed_d     = seed;
                    len_d      = frame_len;
                    gap_d      = gap_len;
                    state_d    = SEND;
                    load_first = 1'b1;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (!eof_q) begin
                        advance = 1'b1;
                    end else if (cont && gap_q == '0) begin
                        load_first = 1'b1;
                    end else if (cont) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                        valid_d   = 1'b0;
                        sof_d     = 1'b0;
                        eof_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        sof_d   = 1'b0;
                        eof_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q <= LEN_W'(1)) begin
                    state_d    = SEND;
                    load_first = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_first) begin
            valid_d = 1'b1;
            sof_d   = 1'b1;
            eof_d   = (cfg_len == LEN_W'(1));
            idx_d   = '0;
            data_d  = word_first;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            lfsr_d  = prbs_first[DATA_W+8:DATA_W];
`endif
        end

        if (advance) begin
            sof_d   = 1'b0;
            eof_d   = ((idx_q + LEN_W'(2)) == len_q);
            idx_d   = idx_q + LEN_W'(1);
            data_d  = word_next;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            lfsr_d  = prbs_next[DATA_W+8:DATA_W];
`endif
        end

        // Abort wins over everything, including an eof transfer on the same edge.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            seed_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            lfsr_q    <= 9'h1FF;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign sof   = sof_q;
    assign eof   = eof_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Directed bench for frame_pattern_gen with hand-computed expected words.
module tb_frame_pattern_gen;

   logic        clock;
   logic        resetN;
   logic        start;
   logic        stop;
   logic [1:0]  mode;
   logic [7:0]  seed;
   logic [15:0] frameLen;
   logic [15:0] gapLen;
   logic        cont;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic        sof;
   logic        eof;
   logic        busy;
   logic        done;

   int checkCount = 0;
   int errorCount = 0;
   int expIdx;
   int transfers;

   frame_pattern_gen #(.DATA_W(8), .LEN_W(16)) dut (
      .clk       (clock),
      .rst_n     (resetN),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .seed      (seed),
      .frame_len (frameLen),
      .gap_len   (gapLen),
      .cont      (cont),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .sof       (sof),
      .eof       (eof),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected it to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value and keep the tallies
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Set up the configuration inputs and the start request for the next edge
   task automatic applyStimulus(input logic st, input logic [1:0] m, input logic [7:0] s,
                                input logic [15:0] fl, input logic [15:0] gl, input logic c);
      start    = st;
      mode     = m;
      seed     = s;
      frameLen = fl;
      gapLen   = gl;
      cont     = c;
   endtask

   // Advance one clock and land 1 ns after the rising edge for sampling/driving
   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Check one beat of the stream
   task automatic checkBeat(input string tag, input logic [7:0] expData, input logic expSof, input logic expEof);
      checkOutput({tag, ".valid"}, {31'd0, valid}, 32'd1);
      checkOutput({tag, ".data"}, {24'd0, data}, {24'd0, expData});
      checkOutput({tag, ".sof"}, {31'd0, sof}, {31'd0, expSof});
      checkOutput({tag, ".eof"}, {31'd0, eof}, {31'd0, expEof});
   endtask

   // Main directed sequence
   initial begin
      resetN = 1'b0;
      ready  = 1'b1;
      stop   = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst.data", {24'd0, data}, 32'd0);
      checkOutput("rst.valid", {31'd0, valid}, 32'd0);
      checkOutput("rst.sof", {31'd0, sof}, 32'd0);
      checkOutput("rst.eof", {31'd0, eof}, 32'd0);
      checkOutput("rst.busy", {31'd0, busy}, 32'd0);
      checkOutput("rst.done", {31'd0, done}, 32'd0);
      resetN = 1'b1;
      nextCycle();

      // Default burst: counter 0x00..0xDB, then done
      $display("[TB] default burst");
      applyStimulus(1'b1, 2'd0, 8'h00, 16'd220, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      checkOutput("burst.busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 220; i++) begin
         checkBeat("burst", 8'(i), (i == 0), (i == 219));
         nextCycle();
      end
      checkOutput("burst.done", {31'd0, done}, 32'd1);
      checkOutput("burst.busyEnd", {31'd0, busy}, 32'd0);
      checkOutput("burst.validEnd", {31'd0, valid}, 32'd0);
      nextCycle();
      checkOutput("burst.donePulse", {31'd0, done}, 32'd0);

      // Backpressure with ready pattern 1,0,0,1,0,0,...
      $display("[TB] backpressure");
      applyStimulus(1'b1, 2'd0, 8'hFE, 16'd4, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      expIdx = 0;
      transfers = 0;
      for (int k = 0; k < 20 && expIdx < 4; k++) begin
         checkBeat("bp", 8'(8'hFE + expIdx), (expIdx == 0), (expIdx == 3));
         ready = ((k % 3) == 0);
         nextCycle();
         if (ready) begin
            expIdx++;
            transfers++;
         end
      end
      checkOutput("bp.transfers", transfers, 32'd4);
      checkOutput("bp.done", {31'd0, done}, 32'd1);
      ready = 1'b1;
      nextCycle();

      // Mode 1: PRBS-9 when built in, counter otherwise
      $display("[TB] mode 1");
      applyStimulus(1'b1, 2'd1, 8'h10, 16'd2, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
`ifdef FRAME_PATTERN_GEN_PRBS_EN
      checkBeat("prbs0", 8'hFF, 1'b1, 1'b0);
      nextCycle();
      checkBeat("prbs1", 8'h83, 1'b0, 1'b1);
`else
      checkBeat("m1w0", 8'h10, 1'b1, 1'b0);
      nextCycle();
      checkBeat("m1w1", 8'h11, 1'b0, 1'b1);
`endif
      nextCycle();
      checkOutput("m1.done", {31'd0, done}, 32'd1);
      nextCycle();

      // Continuous walking-ones with a two-cycle gap, then drop cont
      $display("[TB] continuous walking ones");
      applyStimulus(1'b1, 2'd3, 8'h00, 16'd3, 16'd2, 1'b1);
      nextCycle();
      start = 1'b0;
      checkBeat("walk0", 8'h01, 1'b1, 1'b0);
      nextCycle();
      checkBeat("walk1", 8'h02, 1'b0, 1'b0);
      nextCycle();
      checkBeat("walk2", 8'h04, 1'b0, 1'b1);
      nextCycle();
      checkOutput("gap1.valid", {31'd0, valid}, 32'd0);
      checkOutput("gap1.busy", {31'd0, busy}, 32'd1);
      nextCycle();
      checkOutput("gap2.valid", {31'd0, valid}, 32'd0);
      nextCycle();
      checkBeat("walk2nd0", 8'h01, 1'b1, 1'b0);
      cont = 1'b0;
      nextCycle();
      checkBeat("walk2nd1", 8'h02, 1'b0, 1'b0);
      nextCycle();
      checkBeat("walk2nd2", 8'h04, 1'b0, 1'b1);
      nextCycle();
      checkOutput("walk.done", {31'd0, done}, 32'd1);
      checkOutput("walk.busy", {31'd0, busy}, 32'd0);
      nextCycle();

      // Continuous fixed word with zero gap: next sof right after eof
      $display("[TB] fixed word, zero gap");
      applyStimulus(1'b1, 2'd2, 8'hA5, 16'd2, 16'd0, 1'b1);
      nextCycle();
      start = 1'b0;
      checkBeat("fix0", 8'hA5, 1'b1, 1'b0);
      nextCycle();
      checkBeat("fix1", 8'hA5, 1'b0, 1'b1);
      nextCycle();
      checkBeat("fixNext", 8'hA5, 1'b1, 1'b0);
      stop = 1'b1;
      nextCycle();
      stop = 1'b0;
      cont = 1'b0;
      checkOutput("fixStop.valid", {31'd0, valid}, 32'd0);
      checkOutput("fixStop.busy", {31'd0, busy}, 32'd0);

      // Stop on the same edge as the eof transfer: no done
      $display("[TB] abort on eof");
      applyStimulus(1'b1, 2'd0, 8'h00, 16'd2, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      checkBeat("abort0", 8'h00, 1'b1, 1'b0);
      nextCycle();
      checkBeat("abort1", 8'h01, 1'b0, 1'b1);
      stop = 1'b1;
      nextCycle();
      stop = 1'b0;
      checkOutput("abort.valid", {31'd0, valid}, 32'd0);
      checkOutput("abort.done", {31'd0, done}, 32'd0);
      checkOutput("abort.busy", {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput("abort.doneLate", {31'd0, done}, 32'd0);

      // Start with a zero frame length is ignored
      $display("[TB] ignored starts");
      applyStimulus(1'b1, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      checkOutput("len0.busy", {31'd0, busy}, 32'd0);
      checkOutput("len0.valid", {31'd0, valid}, 32'd0);

      // Start while busy is ignored and the latched config survives
      applyStimulus(1'b1, 2'd0, 8'h20, 16'd3, 16'd0, 1'b0);
      nextCycle();
      checkBeat("busy0", 8'h20, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd2, 8'h50, 16'd9, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      checkBeat("busy1", 8'h21, 1'b0, 1'b0);
      nextCycle();
      checkBeat("busy2", 8'h22, 1'b0, 1'b1);
      nextCycle();
      checkOutput("busyStart.done", {31'd0, done}, 32'd1);
      nextCycle();

      // Asynchronous reset mid-frame, then a fresh start
      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 2'd0, 8'h30, 16'd10, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      nextCycle();
      checkBeat("preRst", 8'h31, 1'b0, 1'b0);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("midRst.valid", {31'd0, valid}, 32'd0);
      checkOutput("midRst.data", {24'd0, data}, 32'd0);
      checkOutput("midRst.sof", {31'd0, sof}, 32'd0);
      checkOutput("midRst.busy", {31'd0, busy}, 32'd0);
      #1;
      resetN = 1'b1;
      applyStimulus(1'b1, 2'd0, 8'h40, 16'd2, 16'd0, 1'b0);
      nextCycle();
      start = 1'b0;
      checkBeat("postRst", 8'h40, 1'b1, 1'b0);
      nextCycle();
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
